// File: rtl/riscv_dp_muldiv.sv
// riscv_dp_muldiv
// Iterative RV32M multiply/divide unit. One operation at a time is taken
// through a valid/ready handshake, computed MP_BITS_PER_CYCLE bits per cycle,
// sign-fixed in one extra cycle and held until the consumer accepts it.
// Division by zero and signed overflow resolve straight from IDLE to DONE.
//
// Ports
//   iclk, irst          clock, synchronous active-high reset
//   ivalid / oready     request handshake (oready high only in IDLE)
//   ictrl               funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   isrc_a / isrc_b     rs1 / rs2, sampled only at the accept edge
//   ovalid / iready     result handshake, result held until accepted
//   oresult             selected result word
//   odivzero, ooverflow special-case flags, qualified by ovalid
//   obusy               unit is not IDLE
module riscv_dp_muldiv #(
    parameter int MP_DATA_WIDTH     = 32,
    parameter int MP_BITS_PER_CYCLE = 1
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     ivalid,
    output logic                     oready,
    input  logic [2:0]               ictrl,
    input  logic [MP_DATA_WIDTH-1:0] isrc_a,
    input  logic [MP_DATA_WIDTH-1:0] isrc_b,
    output logic                     ovalid,
    input  logic                     iready,
    output logic [MP_DATA_WIDTH-1:0] oresult,
    output logic                     odivzero,
    output logic                     ooverflow,
    output logic                     obusy
);

    localparam int W  = MP_DATA_WIDTH;
    localparam int K  = MP_BITS_PER_CYCLE;
    localparam int N  = W / K;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [W-1:0]     op_q, op_d;        // multiplicand magnitude or divisor magnitude
    logic [2*W-1:0]   acc_q, acc_d;      // {high, low} product or {remainder, dividend/quotient}
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     result_q, result_d;
    logic             divzero_q, divzero_d;
    logic             overflow_q, overflow_d;

    // Decode of the incoming request
    logic             in_is_div;
    logic             in_a_signed;
    logic             in_b_signed;
    logic             in_sign_a;
    logic             in_sign_b;
    logic [W-1:0]     in_mag_a;
    logic [W-1:0]     in_mag_b;
    logic             in_divzero;
    logic             in_overflow;

    // Iteration and sign-fix temporaries
    logic [2*W-1:0]   acc_v;
    logic [W:0]       hi_sum;
    logic [W:0]       part_rem;          // shifted partial remainder, one bit wider than W
    logic             borrow;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     quot_fix;
    logic [W-1:0]     rem_fix;

    always_comb begin
        in_is_div   = ictrl[2];
        // a is signed for MUL/MULH/MULHSU/DIV/REM, b for MUL/MULH/DIV/REM
        in_a_signed = ictrl[2] ? ~ictrl[0] : (ictrl[1:0] != 2'b11);
        in_b_signed = ictrl[2] ? ~ictrl[0] : ~ictrl[1];
        in_sign_a   = in_a_signed & isrc_a[W-1];
        in_sign_b   = in_b_signed & isrc_b[W-1];
        in_mag_a    = in_sign_a ? (~isrc_a + 1'b1) : isrc_a;
        in_mag_b    = in_sign_b ? (~isrc_b + 1'b1) : isrc_b;
        in_divzero  = in_is_div && (isrc_b == '0);
        in_overflow = in_is_div && !ictrl[0]
                      && (isrc_a == {1'b1, {(W-1){1'b0}}}) && (&isrc_b);
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        op_d       = op_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        divzero_d  = divzero_q;
        overflow_d = overflow_q;

        acc_v      = acc_q;
        hi_sum     = '0;
        part_rem   = '0;
        borrow     = 1'b0;
        prod_fix   = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
        quot_fix   = (sign_a_q ^ sign_b_q) ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
        rem_fix    = sign_a_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];

        case (state_q)
            ST_IDLE: begin
                if (ivalid) begin
                    ctrl_d     = ictrl;
                    sign_a_d   = in_sign_a;
                    sign_b_d   = in_sign_b;
                    cnt_d      = CW'(N);
                    divzero_d  = 1'b0;
                    overflow_d = 1'b0;
                    if (in_divzero) begin
                        result_d  = ictrl[1] ? isrc_a : '1;
                        divzero_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (in_overflow) begin
                        result_d   = ictrl[1] ? '0 : isrc_a;
                        overflow_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        // Multiply walks the multiplier in the low half and
                        // adds the multiplicand; divide shifts the dividend
                        // out of the low half while quotient bits shift in.
                        acc_d   = {{W{1'b0}}, in_is_div ? in_mag_a : in_mag_b};
                        op_d    = in_is_div ? in_mag_b : in_mag_a;
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                for (int j = 0; j < K; j++) begin
                    if (!ctrl_q[2]) begin
                        hi_sum = {1'b0, acc_v[2*W-1:W]} + (acc_v[0] ? {1'b0, op_q} : '0);
                        acc_v  = {hi_sum, acc_v[W-1:1]};
                    end else begin
                        part_rem = acc_v[2*W-1:W-1];
                        borrow   = part_rem < {1'b0, op_q};
                        // Without borrow the difference is below the divisor,
                        // so W bits hold it exactly.
                        if (!borrow) begin
                            acc_v = {part_rem[W-1:0] - op_q, acc_v[W-2:0], 1'b1};
                        end else begin
                            acc_v = {acc_v[2*W-2:0], 1'b0};
                        end
                    end
                end
                acc_d = acc_v;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                case (ctrl_q)
                    3'b000:                 result_d = prod_fix[W-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod_fix[2*W-1:W];
                    3'b100, 3'b101:         result_d = quot_fix;
                    default:                result_d = rem_fix;
                endcase
                state_d = ST_DONE;
            end

            ST_DONE: begin
                if (iready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            op_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            divzero_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            divzero_q  <= divzero_d;
            overflow_q <= overflow_d;
        end
    end

    assign oready    = (state_q == ST_IDLE);
    assign obusy     = (state_q != ST_IDLE);
    assign ovalid    = (state_q == ST_DONE);
    assign oresult   = result_q;
    assign odivzero  = divzero_q & ovalid;
    assign ooverflow = overflow_q & ovalid;

endmodule

// File: tb/tb_riscv_dp_muldiv.sv
// Testbench for riscv_dp_muldiv: three instances (1, 2 and 4 bits per cycle)
// receive the same operations; results are compared with a plain-arithmetic
// RV32M model and latencies with N+1 (or 0 edges for the special cases).
module tb_riscv_dp_muldiv;

    logic        iclk;
    logic        irst;
    logic [2:0]  ictrl_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        ivalid_r    [3];
    logic        iready_r    [3];
    logic        oready_w    [3];
    logic        ovalid_w    [3];
    logic        obusy_w     [3];
    logic        odivzero_w  [3];
    logic        ooverflow_w [3];
    logic [31:0] oresult_w   [3];

    int checks;
    int errors;

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        riscv_dp_muldiv #(
            .MP_DATA_WIDTH    (32),
            .MP_BITS_PER_CYCLE(1 << gi)
        ) u_dut (
            .iclk     (iclk),
            .irst     (irst),
            .ivalid   (ivalid_r[gi]),
            .oready   (oready_w[gi]),
            .ictrl    (ictrl_r),
            .isrc_a   (a_r),
            .isrc_b   (b_r),
            .ovalid   (ovalid_w[gi]),
            .iready   (iready_r[gi]),
            .oresult  (oresult_w[gi]),
            .odivzero (odivzero_w[gi]),
            .ooverflow(ooverflow_w[gi]),
            .obusy    (obusy_w[gi])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge iclk);
        #1;
    endtask

    // Returns {overflow, divzero, result}
    function automatic logic [33:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        int          ia;
        int          ib;
        int          q;
        logic [31:0] res;
        logic        dz;
        logic        ov;
        ia  = a;
        ib  = b;
        sa  = ia;
        sb  = ib;
        dz  = 1'b0;
        ov  = 1'b0;
        res = '0;
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; res = p[31:0]; end
            3'd1: begin p = sa * sb; res = p[63:32]; end
            3'd2: begin sb = longint'({32'b0, b}); p = sa * sb; res = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; end
            3'd4, 3'd6: begin
                if (b == 0) begin
                    dz  = 1'b1;
                    res = (f == 3'd4) ? 32'hFFFF_FFFF : a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    ov  = 1'b1;
                    res = (f == 3'd4) ? a : 32'h0;
                end else begin
                    q   = (f == 3'd4) ? (ia / ib) : (ia % ib);
                    res = q;
                end
            end
            default: begin
                if (b == 0) begin
                    dz  = 1'b1;
                    res = (f == 3'd5) ? 32'hFFFF_FFFF : a;
                end else begin
                    res = (f == 3'd5) ? (a / b) : (a % b);
                end
            end
        endcase
        return {ov, dz, res};
    endfunction

    // Issue one operation to all instances and follow each through to acceptance.
    // stall_fix >= 0 forces that many iready-low cycles and holds ivalid high meanwhile.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic edz, input logic eov,
                          input int stall_fix);
        int          phase [3];
        int          stall [3];
        int          lat   [3];
        logic [31:0] held  [3];
        int          c;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("oready_idle%0d", i), oready_w[i], 1);
            phase[i] = 0;
            stall[i] = 0;
            held[i]  = '0;
            lat[i]   = (edz || eov) ? 0 : (32 / (1 << i)) + 1;
        end
        ictrl_r = f;
        a_r     = a;
        b_r     = b;
        for (int i = 0; i < 3; i++) ivalid_r[i] = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) ivalid_r[i] = 1'b0;
        // Scramble inputs: only the accept edge may matter
        ictrl_r = 3'($urandom);
        a_r     = $urandom;
        b_r     = $urandom;
        c = 0;
        while ((phase[0] != 3 || phase[1] != 3 || phase[2] != 3) && c < 120) begin
            for (int i = 0; i < 3; i++) begin
                case (phase[i])
                    0: if (ovalid_w[i]) begin
                        check($sformatf("lat%0d", i), c, lat[i]);
                        check($sformatf("res%0d", i), oresult_w[i], er);
                        check($sformatf("divzero%0d", i), odivzero_w[i], edz);
                        check($sformatf("ovf%0d", i), ooverflow_w[i], eov);
                        held[i]  = oresult_w[i];
                        stall[i] = (stall_fix >= 0) ? stall_fix :
                                   (($urandom_range(0, 7) == 0) ? $urandom_range(3, 8) : $urandom_range(0, 2));
                        if (stall[i] == 0) begin
                            iready_r[i] = 1'b1;
                            phase[i]    = 2;
                        end else begin
                            phase[i] = 1;
                            if (stall_fix >= 0) ivalid_r[i] = 1'b1;
                        end
                    end
                    1: begin
                        check($sformatf("hold_valid%0d", i), ovalid_w[i], 1);
                        check($sformatf("hold_res%0d", i), oresult_w[i], held[i]);
                        check($sformatf("hold_flags%0d", i), {odivzero_w[i], ooverflow_w[i]}, {edz, eov});
                        check($sformatf("hold_oready%0d", i), oready_w[i], 0);
                        stall[i]--;
                        if (stall[i] == 0) begin
                            iready_r[i] = 1'b1;
                            ivalid_r[i] = 1'b0;
                            phase[i]    = 2;
                        end
                    end
                    2: begin
                        check($sformatf("ack_oready%0d", i), {oready_w[i], obusy_w[i]}, 2'b10);
                        check($sformatf("ack_ovalid%0d", i), {ovalid_w[i], odivzero_w[i], ooverflow_w[i]}, 3'b000);
                        iready_r[i] = 1'b0;
                        phase[i]    = 3;
                    end
                    default: ;
                endcase
            end
            tick;
            c++;
        end
        for (int i = 0; i < 3; i++) check($sformatf("finished%0d", i), phase[i], 3);
        $display("op f=%0d a=%08h b=%08h exp=%08h dz=%0d ov=%0d", f, a, b, er, edz, eov);
    endtask

    task automatic run_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int stall_fix);
        logic [33:0] m;
        m = model(f, a, b);
        run_op(f, a, b, m[31:0], m[32], m[33], stall_fix);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        checks  = 0;
        errors  = 0;
        irst    = 1'b1;
        ictrl_r = '0;
        a_r     = '0;
        b_r     = '0;
        for (int i = 0; i < 3; i++) begin
            ivalid_r[i] = 1'b0;
            iready_r[i] = 1'b0;
        end
        repeat (3) tick;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready%0d", i), {oready_w[i], obusy_w[i], ovalid_w[i]}, 3'b100);
            check($sformatf("rst_result%0d", i), oresult_w[i], 0);
            check($sformatf("rst_flags%0d", i), {odivzero_w[i], ooverflow_w[i]}, 2'b00);
        end
        irst = 1'b0;
        tick;

        // Multiply corners
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, -1);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, -1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, -1);
        // Signed/unsigned divide
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, -1);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, -1);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, -1);
        // Special cases
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, -1);
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0, -1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, -1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, -1);
        // Backpressure with ivalid held during the stall, then a normal accept
        run_op(3'd0, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 5);
        run_op(3'd5, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b0, -1);

        // Reset in the middle of a divide
        ictrl_r = 3'd4;
        a_r     = 32'h1234_5678;
        b_r     = 32'd3;
        for (int i = 0; i < 3; i++) ivalid_r[i] = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) ivalid_r[i] = 1'b0;
        repeat (10) tick;
        irst = 1'b1;
        tick;
        irst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_ready%0d", i), {oready_w[i], ovalid_w[i]}, 2'b10);
            check($sformatf("abort_result%0d", i), oresult_w[i], 0);
        end
        $display("op reset during DIV");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);

        // Randomized against the model
        for (int n = 0; n < 1000; n++) begin
            run_model(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
